uart_rx_byte: RTL and testbench

- Oversampled 8N1 UART receiver that deserialises the board's serial RX line into bytes.
- Sits directly upstream of the 100x100 data collector.
- Presents each received byte on data_output with a one-cycle data_ready pulse; the collector captures on that pulse's rising edge.
- Also flags framing errors and reports a busy status.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_baud_tick.sv | 28 ++
 rtl/uart_rx_byte.sv | 116 +++++++++++
 tb/tb_uart_rx_byte.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default line settings and tick divisor helper.
package uart_pkg;

    localparam int UART_BAUD       = 9600;
    localparam int UART_OVERSAMPLE = 16;

    // Receiver state encoding
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_HIGH = 3'd4;

    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        return clk_freq / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: counts 0..DIV-1 while enabled, one-clock tick at DIV-1.
module uart_baud_tick #(
    parameter int DIV = 651
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = $clog2(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
    end

    assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/uart_rx_byte.sv
// Oversampled 8N1 UART receiver: synchronised rx, mid-bit sampling, framing error detect.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = UART_BAUD,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DIV        = calc_div(CLK_FREQ, BAUD, OVERSAMPLE)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_output,
    output logic       data_ready,
    output logic       frame_error,
    output logic       busy
);

    localparam int SUB_W = $clog2(OVERSAMPLE);
    localparam logic [SUB_W-1:0] SUB_MID  = SUB_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);

    logic [1:0]       sync_ff;
    logic             rxs;
    logic [2:0]       state;
    logic [SUB_W-1:0] sub_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic             tick;
    logic             tick_clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sync_ff <= 2'b11;
        else
            sync_ff <= {sync_ff[0], rx};
    end
    assign rxs = sync_ff[1];

    // Tick counter is held at zero in IDLE so bit timing aligns to the start edge.
    assign tick_clr = (state == S_IDLE);

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (!tick_clr),
        .clr  (tick_clr),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            sub_cnt     <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            data_output <= '0;
            data_ready  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            data_ready  <= 1'b0;
            frame_error <= 1'b0;
            case (state)
                S_IDLE: begin
                    sub_cnt <= '0;
                    if (!rxs)
                        state <= S_START;
                end
                S_START: if (tick) begin
                    if (sub_cnt == SUB_MID) begin
                        sub_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= rxs ? S_IDLE : S_DATA;
                    end else begin
                        sub_cnt <= sub_cnt + SUB_W'(1);
                    end
                end
                S_DATA: if (tick) begin
                    if (sub_cnt == SUB_LAST) begin
                        sub_cnt   <= '0;
                        shift_reg <= {rxs, shift_reg[7:1]};
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            state   <= S_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        sub_cnt <= sub_cnt + SUB_W'(1);
                    end
                end
                S_STOP: if (tick) begin
                    if (sub_cnt == SUB_LAST) begin
                        sub_cnt <= '0;
                        if (rxs) begin
                            data_output <= shift_reg;
                            data_ready  <= 1'b1;
                            state       <= S_IDLE;
                        end else begin
                            frame_error <= 1'b1;
                            state       <= S_WAIT_HIGH;
                        end
                    end else begin
                        sub_cnt <= sub_cnt + SUB_W'(1);
                    end
                end
                // A held-low line (break) must not be mistaken for new start bits.
                S_WAIT_HIGH: if (rxs) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte: table of frames plus hand-written corner sequences.
module tb_uart_rx_byte;

    localparam int BCLK = 160;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data_output;
    logic       data_ready;
    logic       frame_error;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int dr_cnt = 0;
    int fe_cnt = 0;
    int start_cyc = 0;
    int last_dr_cyc = 0;
    logic [7:0] exp_q[$];
    logic [7:0] prev_out = 8'h00;
    logic       prev_pulse = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         bclks;
        int         gap;
        logic [7:0] exp_out;
        int         exp_dr;
        int         exp_fe;
    } vec_t;

    vec_t vt[8];

    uart_rx_byte #(
        .CLK_FREQ(1_600_000),
        .BAUD(10_000),
        .OVERSAMPLE(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .data_output(data_output),
        .data_ready(data_ready),
        .frame_error(frame_error),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            prev_out   = data_output;
            prev_pulse = 1'b0;
        end else begin
            checks++;
            if (data_output !== prev_out && data_ready !== 1'b1) begin
                errors++;
                $display("FAIL out_stable: got %02h, required %02h", data_output, prev_out);
            end
            if (data_ready || frame_error) begin
                checks++;
                if (data_ready && frame_error) begin
                    errors++;
                    $display("FAIL pulse_exclusive: data_ready and frame_error both 1");
                end
                checks++;
                if (prev_pulse) begin
                    errors++;
                    $display("FAIL pulse_consecutive: pulse in two consecutive cycles");
                end
            end
            if (data_ready) begin
                dr_cnt++;
                last_dr_cyc = cyc;
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_at_ready: got %b, required 0", busy);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ready: got %02h, none expected", data_output);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (data_output !== e) begin
                        errors++;
                        $display("FAIL sb_data: got %02h, required %02h", data_output, e);
                    end
                end
            end
            if (frame_error) fe_cnt++;
            prev_pulse = data_ready | frame_error;
            prev_out   = data_output;
        end
    end

    task automatic check(input string name, input int got, input int req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, got, got, req, req);
        end
    endtask

    task automatic drive(input logic v, input int n);
        rx = v;
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int bclks);
        start_cyc = cyc;
        drive(1'b0, bclks);
        for (int i = 0; i < 8; i++) drive(b[i], bclks);
        drive(stop, bclks);
    endtask

    initial begin
        int dr0, fe0, lat;

        vt = '{
            '{8'hA5, 1'b1, 160,  40, 8'hA5, 1, 0},
            '{8'h00, 1'b1, 160,   0, 8'h00, 1, 0},
            '{8'hFF, 1'b1, 160,   0, 8'hFF, 1, 0},
            '{8'h3C, 1'b1, 160,  40, 8'h3C, 1, 0},
            '{8'h96, 1'b1, 165,  40, 8'h96, 1, 0},
            '{8'h96, 1'b1, 155,  40, 8'h96, 1, 0},
            '{8'h55, 1'b0, 160, 200, 8'h96, 0, 1},
            '{8'h5A, 1'b1, 160,  40, 8'h5A, 1, 0}
        };

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data_output", data_output, 0);
        check("rst_data_ready",  data_ready,  0);
        check("rst_frame_error", frame_error, 0);
        check("rst_busy",        busy,        0);
        rst = 1'b0;
        drive(1'b1, 20);
        check("idle_busy", busy, 0);

        for (int i = 0; i < 8; i++) begin
            dr0 = dr_cnt;
            fe0 = fe_cnt;
            if (vt[i].exp_dr == 1) exp_q.push_back(vt[i].data);
            send_frame(vt[i].data, vt[i].stop, vt[i].bclks);
            drive(1'b1, vt[i].gap);
            check($sformatf("vec%0d_ready_cnt", i), dr_cnt - dr0, vt[i].exp_dr);
            check($sformatf("vec%0d_ferr_cnt", i), fe_cnt - fe0, vt[i].exp_fe);
            check($sformatf("vec%0d_data", i), data_output, vt[i].exp_out);
            if (vt[i].exp_dr == 1) begin
                lat = last_dr_cyc - start_cyc;
                checks++;
                if (lat < 1521 || lat > 1525) begin
                    errors++;
                    $display("FAIL vec%0d_latency: got %0d clks, required 1521..1525", i, lat);
                end
            end
        end

        // Glitch: short low pulse is a false start
        dr0 = dr_cnt;
        drive(1'b0, 50);
        check("glitch_busy_high", busy, 1);
        drive(1'b1, 150);
        check("glitch_busy_low", busy, 0);
        check("glitch_no_ready", dr_cnt - dr0, 0);
        check("glitch_data_kept", data_output, 8'h5A);

        // Framing error followed by a long break
        dr0 = dr_cnt;
        fe0 = fe_cnt;
        send_frame(8'h55, 1'b0, BCLK);
        drive(1'b0, 400);
        check("ferr_pulses", fe_cnt - fe0, 1);
        check("ferr_no_ready", dr_cnt - dr0, 0);
        check("ferr_busy_held", busy, 1);
        check("ferr_data_kept", data_output, 8'h5A);
        drive(1'b1, 160);
        check("ferr_busy_released", busy, 0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, BCLK);
        drive(1'b1, 40);
        check("after_ferr_ready", dr_cnt - dr0, 1);
        check("after_ferr_data", data_output, 8'h81);
        check("after_ferr_no_ferr", fe_cnt - fe0, 1);

        // Reset during data bit 4 of 0xC3
        dr0 = dr_cnt;
        fe0 = fe_cnt;
        begin
            logic [7:0] b;
            b = 8'hC3;
            drive(1'b0, BCLK);
            for (int i = 0; i < 4; i++) drive(b[i], BCLK);
            drive(b[4], 80);
            check("midrst_busy_before", busy, 1);
            rst = 1'b1;
            #1;
            check("midrst_data_output", data_output, 0);
            check("midrst_data_ready",  data_ready,  0);
            check("midrst_frame_error", frame_error, 0);
            check("midrst_busy",        busy,        0);
            rx = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            rst = 1'b0;
        end
        drive(1'b1, 200);
        check("midrst_no_ready", dr_cnt - dr0, 0);
        check("midrst_no_ferr", fe_cnt - fe0, 0);
        check("midrst_idle", busy, 0);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, BCLK);
        drive(1'b1, 40);
        check("after_rst_ready", dr_cnt - dr0, 1);
        check("after_rst_data", data_output, 8'h7E);

        check("sb_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
